// File: rtl/pipe_track_pkg.sv
// Shared pipeline definitions: opcode constants, control FSM encoding and
// the per-stage tag bundle carried through E, M and W.
package pipe_track_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_NOP  = 7'b0010011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [6:0] opcode;
    } tag_t;

    // Bubble: no instruction, no destination, NOP opcode.
    function automatic tag_t bubble_tag(input logic [6:0] nop_op);
        tag_t t;
        t.valid  = 1'b0;
        t.rd     = 5'd0;
        t.opcode = nop_op;
        return t;
    endfunction

    // Tag of the D-stage instruction; rd is only tracked for real writers.
    function automatic tag_t d_tag(input logic valid, input logic we,
                                   input logic [4:0] rd, input logic [6:0] opcode);
        tag_t t;
        t.valid  = valid;
        t.rd     = (valid && we) ? rd : 5'd0;
        t.opcode = opcode;
        return t;
    endfunction

endpackage

// File: rtl/pipe_track_if.sv
// Bundle between the pipeline tracker and the surrounding core: D-stage
// instruction info and hazard inputs in, enables/flush and stage tags out.
interface pipe_track_if #(
    parameter int CNT_W = 32
);
    logic             fetch_stall;
    logic             redirect;
    logic             valid_d;
    logic             we_d;
    logic [4:0]       rd_d;
    logic [6:0]       opcode_d;

    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             de_bubble;
    logic [4:0]       rd_e;
    logic [4:0]       rd_m;
    logic [4:0]       rd_w;
    logic [6:0]       opcode_e;
    logic             valid_e;
    logic             valid_m;
    logic             valid_w;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output fetch_stall, redirect, valid_d, we_d, rd_d, opcode_d,
        input  pc_en, fd_en, fd_flush, de_bubble,
        input  rd_e, rd_m, rd_w, opcode_e, valid_e, valid_m, valid_w, stall_cnt
    );

    modport slave (
        input  fetch_stall, redirect, valid_d, we_d, rd_d, opcode_d,
        output pc_en, fd_en, fd_flush, de_bubble,
        output rd_e, rd_m, rd_w, opcode_e, valid_e, valid_m, valid_w, stall_cnt
    );
endinterface

// File: rtl/pipe_tag_reg.sv
// One pipeline stage tag register. A bubble request overrides load; with
// neither the stage holds its contents.
module pipe_tag_reg
    import pipe_track_pkg::*;
#(
    parameter logic [6:0] NOP_OP = 7'b0010011
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    tag_t q_r;

    // Stage register: reset and bubble load the NOP tag, load captures d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= bubble_tag(NOP_OP);
        end else if (bubble) begin
            q_r <= bubble_tag(NOP_OP);
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_track.sv
// Pipeline control: holds fetch after reset, turns stall/redirect into
// PC and F/D enables, inserts bubbles into E, tracks rd tags through
// E/M/W and counts stall cycles.
module pipe_track
    import pipe_track_pkg::*;
#(
    parameter int         RESET_HOLD = 2,
    parameter int         CNT_W      = 32,
    parameter logic [6:0] NOP_OP     = 7'b0010011
) (
    input  logic        clk,
    input  logic        reset_n,
    pipe_track_if.slave bus
);

    localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD - 1);

    state_e           state_r;
    state_e           state_s;
    logic [3:0]       hold_r;
    logic [3:0]       hold_s;
    logic             pc_en_s;
    logic             fd_en_s;
    logic             fd_flush_s;
    logic             de_bubble_s;
    logic             stall_inc_s;
    logic [CNT_W-1:0] stall_cnt_r;
    tag_t             tag_d_s;
    tag_t             tag_e_s;
    tag_t             tag_m_s;
    tag_t             tag_w_s;
    logic [6:0]       unused_op_w_s;

    // Control state and post-reset hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
            hold_r  <= HOLD_INIT;
        end else begin
            state_r <= state_s;
            hold_r  <= hold_s;
        end
    end

    // Next state and combinational pipeline controls; redirect beats stall.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        pc_en_s     = 1'b0;
        fd_en_s     = 1'b0;
        fd_flush_s  = 1'b1;
        de_bubble_s = 1'b1;
        stall_inc_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (hold_r == 4'd0) begin
                    state_s = ST_RUN;
                end else begin
                    hold_s = hold_r - 4'd1;
                end
            end
            ST_RUN: begin
                if (bus.redirect) begin
                    pc_en_s     = 1'b1;
                    fd_en_s     = 1'b1;
                    fd_flush_s  = 1'b1;
                    de_bubble_s = 1'b1;
                end else if (bus.fetch_stall) begin
                    pc_en_s     = 1'b0;
                    fd_en_s     = 1'b0;
                    fd_flush_s  = 1'b0;
                    de_bubble_s = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    pc_en_s     = 1'b1;
                    fd_en_s     = 1'b1;
                    fd_flush_s  = 1'b0;
                    de_bubble_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_INIT;
                hold_s  = HOLD_INIT;
            end
        endcase
        // While reset is asserted the controls must read as held/flushed
        // regardless of the register contents.
        if (!reset_n) begin
            pc_en_s     = 1'b0;
            fd_en_s     = 1'b0;
            fd_flush_s  = 1'b1;
            de_bubble_s = 1'b1;
            stall_inc_s = 1'b0;
        end else begin
            stall_inc_s = stall_inc_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign tag_d_s = d_tag(bus.valid_d, bus.we_d, bus.rd_d, bus.opcode_d);

    pipe_tag_reg #(.NOP_OP(NOP_OP)) u_tag_e (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .bubble  (de_bubble_s),
        .d       (tag_d_s),
        .q       (tag_e_s)
    );

    pipe_tag_reg #(.NOP_OP(NOP_OP)) u_tag_m (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .bubble  (1'b0),
        .d       (tag_e_s),
        .q       (tag_m_s)
    );

    pipe_tag_reg #(.NOP_OP(NOP_OP)) u_tag_w (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b1),
        .bubble  (1'b0),
        .d       (tag_m_s),
        .q       (tag_w_s)
    );

    // The W-stage opcode is carried for completeness but not exported.
    assign unused_op_w_s = tag_w_s.opcode;

    assign bus.pc_en     = pc_en_s;
    assign bus.fd_en     = fd_en_s;
    assign bus.fd_flush  = fd_flush_s;
    assign bus.de_bubble = de_bubble_s;
    assign bus.rd_e      = tag_e_s.rd;
    assign bus.opcode_e  = tag_e_s.opcode;
    assign bus.valid_e   = tag_e_s.valid;
    assign bus.rd_m      = tag_m_s.rd;
    assign bus.valid_m   = tag_m_s.valid;
    assign bus.rd_w      = tag_w_s.rd;
    assign bus.valid_w   = tag_w_s.valid;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_track.sv
// Bench for pipe_track: two instances (32-bit and 4-bit stall counter)
// share one stimulus stream; a stage-history model predicts every output.
module tb_pipe_track;

    localparam int         HOLD = 2;
    localparam logic [6:0] NOP  = 7'b0010011;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    pipe_track_if #(.CNT_W(32)) bus ();
    pipe_track_if #(.CNT_W(4))  bus4 ();

    assign bus4.fetch_stall = bus.fetch_stall;
    assign bus4.redirect    = bus.redirect;
    assign bus4.valid_d     = bus.valid_d;
    assign bus4.we_d        = bus.we_d;
    assign bus4.rd_d        = bus.rd_d;
    assign bus4.opcode_d    = bus.opcode_d;

    pipe_track #(.RESET_HOLD(HOLD), .CNT_W(32), .NOP_OP(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    pipe_track #(.RESET_HOLD(HOLD), .CNT_W(4), .NOP_OP(NOP)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic [6:0] op;
    } ent_t;

    // Model: what entered E one, two and three edges ago.
    ent_t    s_e, s_m, s_w;
    int      edges;
    longint  stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s_e    = '{1'b0, 5'd0, NOP};
        s_m    = s_e;
        s_w    = s_e;
        edges  = 0;
        stalls = 0;
    endtask

    task automatic check_regs();
        longint sat4;
        sat4 = (stalls > 15) ? 64'd15 : stalls;
        chk("rd_e",     64'(bus.rd_e),     64'(s_e.rd));
        chk("valid_e",  64'(bus.valid_e),  64'(s_e.v));
        chk("opcode_e", 64'(bus.opcode_e), 64'(s_e.op));
        chk("rd_m",     64'(bus.rd_m),     64'(s_m.rd));
        chk("valid_m",  64'(bus.valid_m),  64'(s_m.v));
        chk("rd_w",     64'(bus.rd_w),     64'(s_w.rd));
        chk("valid_w",  64'(bus.valid_w),  64'(s_w.v));
        chk("stall_cnt32", 64'(bus.stall_cnt),  64'(stalls));
        chk("stall_cnt4",  64'(bus4.stall_cnt), 64'(sat4));
    endtask

    // One clock cycle: drive D/hazard inputs, check controls before the
    // edge, advance the model, check registered state after the edge.
    task automatic cyc(input logic fs, input logic rdr, input logic vd, input logic we,
                       input logic [4:0] rd, input logic [6:0] op);
        bit   run;
        ent_t n;
        logic [3:0] ctl;
        bus.fetch_stall = fs;
        bus.redirect    = rdr;
        bus.valid_d     = vd;
        bus.we_d        = we;
        bus.rd_d        = rd;
        bus.opcode_d    = op;
        #1;
        run = (edges >= HOLD);
        // {pc_en, fd_en, fd_flush, de_bubble}
        if (!run)      ctl = 4'b0011;
        else if (rdr)  ctl = 4'b1111;
        else if (fs)   ctl = 4'b0001;
        else           ctl = 4'b1100;
        chk("pc_en",     64'(bus.pc_en),     64'(ctl[3]));
        chk("fd_en",     64'(bus.fd_en),     64'(ctl[2]));
        chk("fd_flush",  64'(bus.fd_flush),  64'(ctl[1]));
        chk("de_bubble", 64'(bus.de_bubble), 64'(ctl[0]));
        if (!run || rdr || fs) n = '{1'b0, 5'd0, NOP};
        else                   n = '{vd, (vd && we) ? rd : 5'd0, op};
        if (run && !rdr && fs) stalls++;
        @(posedge clk);
        s_w = s_m;
        s_m = s_e;
        s_e = n;
        edges++;
        #1;
        check_regs();
    endtask

    initial begin
        bus.fetch_stall = 1'b0;
        bus.redirect    = 1'b0;
        bus.valid_d     = 1'b0;
        bus.we_d        = 1'b0;
        bus.rd_d        = 5'd0;
        bus.opcode_d    = 7'd0;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_pc_en",    64'(bus.pc_en),    64'd0);
        chk("rst_fd_flush", 64'(bus.fd_flush), 64'd1);
        chk("rst_de_bub",   64'(bus.de_bubble), 64'd1);
        check_regs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Post-reset hold: two cycles held, running from the third.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, OP_R);
        chk("hold_valid_e", 64'(bus.valid_e), 64'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, OP_R);
        chk("hold_valid_e2", 64'(bus.valid_e), 64'd0);

        // Tag walks E -> M -> W.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, OP_R);
        chk("dir_rd_e5", 64'(bus.rd_e), 64'd5);
        chk("dir_op_e",  64'(bus.opcode_e), 64'(OP_R));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, NOP);
        chk("dir_rd_m5", 64'(bus.rd_m), 64'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, NOP);
        chk("dir_rd_w5", 64'(bus.rd_w), 64'd5);
        chk("dir_vw",    64'(bus.valid_w), 64'd1);

        // x0 is never tracked.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, OP_R);
        chk("x0_rd_e", 64'(bus.rd_e), 64'd0);

        // Three stall cycles, then the held instruction enters E.
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, OP_R);
        chk("stall3", 64'(bus.stall_cnt), 64'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, OP_R);
        chk("stall_rel_rd_e", 64'(bus.rd_e), 64'd7);

        // Redirect beats stall and does not count.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, OP_R);
        chk("redir_rd_e",  64'(bus.rd_e), 64'd0);
        chk("redir_stall", 64'(bus.stall_cnt), 64'd3);

        // Saturation of the narrow counter.
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, NOP);
        chk("sat4", 64'(bus4.stall_cnt), 64'd15);

        // Reset in the middle of a stall with a live tag in M.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, OP_R);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, OP_R);
        chk("pre_rst_rd_m", 64'(bus.rd_m), 64'd3);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rd_m",  64'(bus.rd_m), 64'd0);
        chk("async_cnt",   64'(bus.stall_cnt), 64'd0);
        chk("async_pc_en", 64'(bus.pc_en), 64'd0);
        chk("async_fd_en", 64'(bus.fd_en), 64'd0);
        chk("async_flush", 64'(bus.fd_flush), 64'd1);
        check_regs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        // Stall and redirect are ignored during the hold.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, OP_R);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, OP_R);
        chk("init_no_count", 64'(bus.stall_cnt), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                1'($urandom), 1'($urandom), 5'($urandom), 7'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_track.md
Name: pipe_track

Overview:
- Pipeline-control block that feeds the hazard/bypass unit and acts on its stall decision.
- Carries destination-register and opcode tags through the E, M and W stages, and presents rd_e/rd_m/rd_w/opcode_e to the hazard unit.
- Consumes fetch_stall and the branch redirect, and generates the PC and F/D register enables, the F/D flush, and bubble insertion into E.
- Sequences a post-reset fetch hold and counts stall cycles for performance monitoring.

Parameters:
- RESET_HOLD, 2: cycles fetch is held after reset deassertion; legal range 1..15.
- CNT_W, 32: width of the stall-cycle counter.
- NOP_OP, 7'b0010011: opcode loaded into E for bubbles and at reset.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- fetch_stall  in  1  stall request from the hazard/bypass unit
- redirect  in  1  taken branch/jump resolved in E; squash younger instructions
- valid_d  in  1  D stage holds a real instruction
- we_d  in  1  D-stage instruction writes rd
- rd_d  in  5  D-stage destination register
- opcode_d  in  7  D-stage opcode
- pc_en  out  1  PC register update enable
- fd_en  out  1  F/D register load enable
- fd_flush  out  1  clear F/D register to a bubble
- de_bubble  out  1  E is loaded with a bubble this cycle
- rd_e, rd_m, rd_w  out  5 each  destination tag per stage; 0 for bubbles and non-writers
- opcode_e  out  7  E-stage opcode
- valid_e, valid_m, valid_w  out  1 each  stage holds a real instruction
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Async reset (reset_n=0):
  - rd_e/m/w=0, opcode_e=NOP_OP, valid_e/m/w=0, stall_cnt=0.
  - State INIT, hold counter = RESET_HOLD-1.
  - Combinational outputs while reset_n=0: pc_en=0, fd_en=0, fd_flush=1, de_bubble=1.
- FSM states:
  - INIT: pc_en=0, fd_en=0, fd_flush=1, de_bubble=1. The hold counter decrements each cycle. When the counter is 0, go to RUN on that edge. The total hold is exactly RESET_HOLD cycles after the first clock edge with reset_n=1.
  - RUN: normal operation; never returns to INIT except through reset.
  - redirect and fetch_stall are ignored in INIT.
- RUN, per cycle, in priority order:
  - redirect=1: fd_flush=1, fd_en=1, pc_en=1, de_bubble=1. E is loaded with a bubble. stall_cnt is not incremented, even if fetch_stall=1.
  - fetch_stall=1: pc_en=0, fd_en=0, fd_flush=0, de_bubble=1. E is loaded with a bubble. stall_cnt increments, saturating at all-ones.
  - Otherwise: pc_en=1, fd_en=1, fd_flush=0, de_bubble=0. E loads valid_e=valid_d, opcode_e=opcode_d, and rd_e = (valid_d && we_d) ? rd_d : 0.
- Bubble contents: valid=0, rd=0, opcode=NOP_OP.
- E→M and M→W advance every cycle unconditionally (no back-pressure): rd_m<=rd_e, valid_m<=valid_e, rd_w<=rd_m, valid_w<=valid_m.
  - An instruction in E when redirect fires (the branch itself) proceeds to M normally.
- rd_d=0 with we_d=1 yields rd_e=0; x0 is never tracked.
- Timing:
  - Control outputs are combinational from state and inputs.
  - All tag/valid registers and stall_cnt update only on posedge clk.
  - Latency D→E is 1 cycle; a tag appears on rd_w 3 cycles after leaving D.
- Reset asserted mid-stall or mid-redirect: all state clears immediately; outputs take reset values within the same cycle.

Decomposition:
- Shared pipeline package holds:
  - opcode constants: OP_LOAD 0000011, OP_JAL 1101111, OP_JALR 1100111, OP_NOP/OP_IMM 0010011.
  - FSM state encoding: INIT, RUN.
  - Stage tag bundle: valid, rd[4:0], opcode[6:0].
- One natural sub-module: pipe_tag_reg, a single-stage tag register with load, bubble and async active-low reset. Instantiate it three times (E, M, W).

Test Plan:
- Reset then release, RESET_HOLD=2, fetch_stall=0 → pc_en=0 for first 2 cycles after release, pc_en=1 from cycle 3; valid_e=0 throughout the hold.
- RUN, D: valid_d=1, we_d=1, rd_d=5, opcode_d=0110011 → next cycle rd_e=5, opcode_e=0110011; cycle+2 rd_m=5; cycle+3 rd_w=5, valid_w=1.
- RUN, fetch_stall=1 for 3 cycles with rd_d=7 → pc_en=fd_en=0, de_bubble=1 each cycle; rd_e=0, valid_e=0; stall_cnt goes 0→3; after release rd_e=7.
- RUN, redirect=1 and fetch_stall=1 in the same cycle, rd_d=9 → fd_flush=1, pc_en=1, rd_e=0 next cycle, stall_cnt unchanged.
- CNT_W=4, fetch_stall held 20 cycles → stall_cnt saturates at 15 and stays at 15.
- Drive reset_n=0 mid-stall with rd_m=3 → rd_m=0, stall_cnt=0, pc_en=0 immediately without a clock edge; FSM re-enters INIT.
